// File: rtl/vga_sync_gen_pkg.sv
// rtl/vga_sync_gen_pkg.sv - shared 640x480@60 raster constants, sync polarity and control-bit type
package vga_sync_gen_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Both syncs are negative polarity for this mode.
  localparam logic HS_ACTIVE_LVL = 1'b0;
  localparam logic VS_ACTIVE_LVL = 1'b0;

  typedef struct packed {
    logic active;
    logic hs_n;
    logic vs_n;
  } raster_ctl_t;

  localparam raster_ctl_t CTL_IDLE = '{active: 1'b0, hs_n: ~HS_ACTIVE_LVL, vs_n: ~VS_ACTIVE_LVL};

  function automatic logic in_window(input logic [9:0] cnt, input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - resettable fixed-depth shift register for raster control bits
module vga_delay_line #(
  parameter int               DEPTH   = 2,
  parameter int               WIDTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;
  logic [DEPTH-1:0][WIDTH-1:0] stage_d;

  always_comb begin
    stage_d    = '0;
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stage_q <= {DEPTH{RST_VAL}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster counters, sync/blank alignment and gated colour register
// Optional build macro: VGA_TEST_BORDER_EN forces a white ring around the active area.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int PIPE_LAT = 1,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic       iVGA_CLK,
  input  logic       reset_n,
  output logic [9:0] oVGA_X,
  output logic [9:0] oVGA_Y,
  input  logic       iRed,
  input  logic       iGreen,
  input  logic       iBlue,
  output logic       oVGA_R,
  output logic       oVGA_G,
  output logic       oVGA_B,
  output logic       oVGA_HS,
  output logic       oVGA_VS,
  output logic       oVGA_BLANK_N,
  output logic       oFrame_tick
);

  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam int         CTL_W  = $bits(raster_ctl_t);

  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  raster_ctl_t raw_ctl;
  raster_ctl_t pipe_ctl;
  raster_ctl_t out_ctl_q, out_ctl_d;
  logic [2:0]  rgb_q, rgb_d;
  logic        force_white;

  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
    end
  end

  always_ff @(posedge iVGA_CLK) begin
    if (!reset_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  always_comb begin
    raw_ctl.active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    raw_ctl.hs_n   = in_window(h_cnt_q, H_SS, H_SE) ? HS_ACTIVE_LVL : ~HS_ACTIVE_LVL;
    raw_ctl.vs_n   = in_window(v_cnt_q, V_SS, V_SE) ? VS_ACTIVE_LVL : ~VS_ACTIVE_LVL;
  end

  // PIPE_LAT stages here line control up with the renderer colour; the output
  // register below supplies the final stage shared with the colour register.
  vga_delay_line #(
    .DEPTH  (PIPE_LAT),
    .WIDTH  (CTL_W),
    .RST_VAL(CTL_IDLE)
  ) u_ctl_dly (
    .clk    (iVGA_CLK),
    .reset_n(reset_n),
    .din    (raw_ctl),
    .dout   (pipe_ctl)
  );

`ifdef VGA_TEST_BORDER_EN
  localparam logic [9:0] H_ACT_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);

  logic raw_ring;
  logic pipe_ring;

  assign raw_ring = (h_cnt_q == '0) || (h_cnt_q == H_ACT_LAST) ||
                    (v_cnt_q == '0) || (v_cnt_q == V_ACT_LAST);

  vga_delay_line #(
    .DEPTH  (PIPE_LAT),
    .WIDTH  (1),
    .RST_VAL(1'b0)
  ) u_ring_dly (
    .clk    (iVGA_CLK),
    .reset_n(reset_n),
    .din    (raw_ring),
    .dout   (pipe_ring)
  );

  assign force_white = pipe_ring & pipe_ctl.active;
`else
  assign force_white = 1'b0;
`endif

  always_comb begin
    out_ctl_d = pipe_ctl;
    rgb_d     = {iRed, iGreen, iBlue} & {3{pipe_ctl.active}};
    if (force_white) begin
      rgb_d = 3'b111;
    end
  end

  always_ff @(posedge iVGA_CLK) begin
    if (!reset_n) begin
      out_ctl_q <= CTL_IDLE;
      rgb_q     <= '0;
    end else begin
      out_ctl_q <= out_ctl_d;
      rgb_q     <= rgb_d;
    end
  end

  assign oVGA_X       = h_cnt_q;
  assign oVGA_Y       = v_cnt_q;
  assign oVGA_R       = rgb_q[2];
  assign oVGA_G       = rgb_q[1];
  assign oVGA_B       = rgb_q[0];
  assign oVGA_HS      = out_ctl_q.hs_n;
  assign oVGA_VS      = out_ctl_q.vs_n;
  assign oVGA_BLANK_N = out_ctl_q.active;
  assign oFrame_tick  = (h_cnt_q == '0) && (v_cnt_q == V_ACT);

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - checks a default-timing and a reduced-timing vga_sync_gen against a raster model
module tb_vga_sync_gen;

  localparam int LAT = 1;

  typedef struct {
    int ha, hfp, hs, hbp, va, vfp, vs, vbp;
  } tm_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] rgb;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       tick;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] rgb_in = 3'b111;

  logic [9:0] x0, y0, x1, y1;
  logic r0, g0, b0, hs0, vs0, bl0, tk0;
  logic r1, g1, b1, hs1, vs1, bl1, tk1;
  obs_t obs0, obs1;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  always #5 clk = ~clk;

  vga_sync_gen #(.PIPE_LAT(LAT)) u_dut_std (
    .iVGA_CLK(clk), .reset_n(reset_n), .oVGA_X(x0), .oVGA_Y(y0),
    .iRed(rgb_in[2]), .iGreen(rgb_in[1]), .iBlue(rgb_in[0]),
    .oVGA_R(r0), .oVGA_G(g0), .oVGA_B(b0), .oVGA_HS(hs0), .oVGA_VS(vs0),
    .oVGA_BLANK_N(bl0), .oFrame_tick(tk0)
  );

  vga_sync_gen #(
    .PIPE_LAT(LAT), .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(48), .V_FP(3), .V_SYNC(2), .V_BP(4)
  ) u_dut_small (
    .iVGA_CLK(clk), .reset_n(reset_n), .oVGA_X(x1), .oVGA_Y(y1),
    .iRed(rgb_in[2]), .iGreen(rgb_in[1]), .iBlue(rgb_in[0]),
    .oVGA_R(r1), .oVGA_G(g1), .oVGA_B(b1), .oVGA_HS(hs1), .oVGA_VS(vs1),
    .oVGA_BLANK_N(bl1), .oFrame_tick(tk1)
  );

  assign obs0 = {x0, y0, r0, g0, b0, hs0, vs0, bl0, tk0};
  assign obs1 = {x1, y1, r1, g1, b1, hs1, vs1, bl1, tk1};

  function automatic tm_t tm_of(input int k);
    tm_t t;
    if (k == 0) t = '{640, 16, 96, 48, 480, 10, 2, 33};
    else        t = '{64, 4, 8, 4, 48, 3, 2, 4};
    return t;
  endfunction

  // Output at cycle n (n cycles after the last reset edge) from the raster rules.
  function automatic obs_t model(input tm_t t, input int n, input logic [2:0] prev_rgb);
    obs_t o;
    int   ht, vt, hp, vp;
    logic act;
    ht = t.ha + t.hfp + t.hs + t.hbp;
    vt = t.va + t.vfp + t.vs + t.vbp;
    o.x     = 10'(n % ht);
    o.y     = 10'((n / ht) % vt);
    o.tick  = ((n % ht) == 0) && (((n / ht) % vt) == t.va);
    o.rgb   = 3'b000;
    o.hs    = 1'b1;
    o.vs    = 1'b1;
    o.blank = 1'b0;
    if (n >= LAT + 1) begin
      hp  = (n - LAT - 1) % ht;
      vp  = ((n - LAT - 1) / ht) % vt;
      act = (hp < t.ha) && (vp < t.va);
      o.hs    = !((hp >= t.ha + t.hfp) && (hp < t.ha + t.hfp + t.hs));
      o.vs    = !((vp >= t.va + t.vfp) && (vp < t.va + t.vfp + t.vs));
      o.blank = act;
      o.rgb   = act ? prev_rgb : 3'b000;
`ifdef VGA_TEST_BORDER_EN
      if (act && (hp == 0 || hp == t.ha - 1 || vp == 0 || vp == t.va - 1)) o.rgb = 3'b111;
`endif
    end
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  int         n = 0;
  logic [2:0] prev_in = 3'b000;
  bit         model_ok = 1'b0;
  bit         first_run = 1'b1;

  always @(posedge clk) begin
    if (!reset_n) n = 0;
    else          n = n + 1;
    prev_in  = rgb_in;
    model_ok = 1'b1;
  end

  int hs_lo0 = 0, bl_hi0 = 0, hs_first0 = -1;
  int tick1 = 0, tick_n1 = -1, vs_lo1 = 0, vs_first1 = -1;

  always @(negedge clk) begin
    if (model_ok) begin
      chk($sformatf("std_n%0d", n), 32'(obs0), 32'(model(tm_of(0), n, prev_in)));
      chk($sformatf("small_n%0d", n), 32'(obs1), 32'(model(tm_of(1), n, prev_in)));
      if (first_run) begin
        if (n >= 802 && n <= 1601) begin
          if (!hs0) hs_lo0++;
          if (bl0) bl_hi0++;
          if (!hs0 && hs_first0 < 0) hs_first0 = n;
        end
        if (n == 1602) begin
          chk("line_hs_low_cycles", 32'(hs_lo0), 32'd96);
          chk("line_hs_first", 32'(hs_first0), 32'd1458);
          chk("line_blank_hi_cycles", 32'(bl_hi0), 32'd640);
        end
        if (n == 799) chk("x_last", 32'(x0), 32'd799);
        if (n == 800) chk("x_wrap_y_inc", 32'({x0, y0}), 32'({10'd0, 10'd1}));
        if (n < 4560 && tk1) begin
          tick1++;
          tick_n1 = n;
        end
        if (n >= 2 && n <= 4561 && !vs1) begin
          vs_lo1++;
          if (vs_first1 < 0) vs_first1 = n;
        end
        if (n == 4562) begin
          chk("frame_tick_count", 32'(tick1), 32'd1);
          chk("frame_tick_at", 32'(tick_n1), 32'd3840);
          chk("frame_vs_low_cycles", 32'(vs_lo1), 32'd160);
          chk("frame_vs_first", 32'(vs_first1), 32'd4082);
        end
        if (n == 4559) chk("frame_last_xy", 32'({x1, y1}), 32'({10'd79, 10'd56}));
        if (n == 4560) chk("frame_wrap_xy", 32'({x1, y1}), 32'({10'd0, 10'd0}));
      end
    end
  end

  initial begin
    int cyc;
    int budget;
    repeat (5) @(negedge clk);
    chk("rst_xy", 32'({x0, y0}), 32'd0);
    chk("rst_sync_blank", 32'({hs0, vs0, bl0, tk0}), 32'b1100);
    chk("rst_rgb", 32'({r0, g0, b0}), 32'd0);
    reset_n = 1'b1;
    chk("first_xy", 32'({x0, y0}), 32'd0);
    @(negedge clk);
    chk("red_n1", 32'(r0), 32'd0);
    @(negedge clk);
    chk("red_n2", 32'(r0), 32'd1);
    chk("x_n2", 32'(x0), 32'd2);
    // Constant white input first: colour must track blank exactly.
    repeat (1800) @(negedge clk);
    cyc = 0;
    repeat (8200) begin
      rgb_in = 3'(cyc ^ (cyc >> 4) ^ (cyc >> 7));
      cyc++;
      @(negedge clk);
    end
    rgb_in = 3'b000;
    budget = 6000;
    while (!(x1 == 10'd30 && y1 == 10'd20) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("mid_reset_reached", 32'(budget > 0), 32'd1);
    first_run = 1'b0;
    reset_n   = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    rgb_in  = 3'b101;
    chk("mid_rst_xy", 32'({x0, y0, x1, y1}), 32'd0);
    chk("mid_rst_ctl_c0", 32'({hs0, bl0, hs1, bl1}), 32'b1010);
    @(negedge clk);
    chk("mid_rst_ctl_c1", 32'({hs0, bl0, hs1, bl1}), 32'b1010);
    @(negedge clk);
    chk("mid_rst_ctl_c2", 32'({bl0, bl1, r1, g1, b1}), 32'b11101);
    repeat (3000) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Raster timing generator and colour output stage for the VGA path. It drives the pixel coordinates consumed by the pattern/sprite renderer and registers the renderer's 1-bit RGB back. It then emits it to the DAC with sync and blank signals delayed to line up with the renderer's pipeline. It also emits a once-per-frame tick at the start of vertical blank, so game logic can update the grid between frames.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync width, back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch, sync width, back porch (lines)
- PIPE_LAT, 1, renderer latency in cycles from coordinate to iRed/iGreen/iBlue (≥1)
- iVGA_CLK  in  1  pixel clock (25 MHz for defaults)
- reset_n  in  1  synchronous, active-low reset
- oVGA_X  out  10  current horizontal counter value (0..H_TOTAL-1)
- oVGA_Y  out  10  current vertical counter value (0..V_TOTAL-1)
- iRed / iGreen / iBlue  in  1 each  renderer colour for the coordinate presented PIPE_LAT cycles earlier
- oVGA_R / oVGA_G / oVGA_B  out  1 each  registered colour to DAC, forced 0 outside active area
- oVGA_HS / oVGA_VS  out  1 each  sync, active-low
- oVGA_BLANK_N  out  1  high during active video
- oFrame_tick  out  1  one-cycle pulse at start of vertical blank

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). All arithmetic is 10-bit unsigned. Parameters must keep totals ≤1023.
- h_cnt increments every cycle. At H_TOTAL-1 it wraps to 0 and v_cnt increments. v_cnt wraps to 0 when h_cnt and v_cnt are both at their last value (simultaneous wrap gives (0,0)).
- oVGA_X/oVGA_Y present h_cnt/v_cnt directly from the counter registers. They are not clamped during blanking; the renderer's output there is discarded.
- Raw active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- Raw hs low for H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC; raw vs low for V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC.
- Raw active/hs/vs pass through a shift register of depth PIPE_LAT+1.
- Colour register: on each edge, oVGA_R <= iRed & active delayed PIPE_LAT; G and B are handled the same way.
- oFrame_tick is high for exactly the one cycle where h_cnt=0 and v_cnt=V_ACTIVE. It is undelayed.

## Timing
- Reset: h_cnt=v_cnt=0, all delay stages cleared to inactive (hs=1, vs=1, active=0). Outputs: oVGA_R/G/B=0, oVGA_HS=1, oVGA_VS=1, oVGA_BLANK_N=0, oFrame_tick=0, oVGA_X=oVGA_Y=0.
- First cycle after reset_n rises: counters at (0,0). Reset asserted mid-frame restarts the frame at (0,0) on the next edge with no partial-line recovery.
- Coordinate→pixel latency: colour and syncs for counter value (h,v) presented in cycle t appear on the outputs in cycle t+PIPE_LAT+1. All outputs except oVGA_X/oVGA_Y/oFrame_tick are registered.
- Defaults: line 800 cycles, frame 420000 cycles. hs low for 96 cycles; vs low for 2 lines (1600 cycles).

## Configuration
- VGA_TEST_BORDER_EN: when defined, the active pixel on the outer ring is forced to white (R=G=B=1) in the colour register, overriding iRed/iGreen/iBlue. The ring is h_cnt ∈ {0, H_ACTIVE-1} or v_cnt ∈ {0, V_ACTIVE-1}, delayed the same PIPE_LAT. Use it for monitor alignment. When undefined, the colour is purely the gated renderer input.

## Structure
- Shared package/define file holds the default timing constants (640x480@60), H_TOTAL/V_TOTAL derivation, and sync polarity constants, so the renderer and game logic use the same active dimensions.
- One sub-module: vga_delay_line (parameterised depth, width 3), used for the active/hs/vs alignment.

## Test plan
- Reset release: hold reset_n=0 for 5 cycles -> outputs at reset values. First cycle after release X=0,Y=0; colour with iRed=1 appears on oVGA_R at cycle PIPE_LAT+1 = 2.
- Line timing: run one line -> oVGA_HS low exactly for counter 656..751 (delayed 2). oVGA_BLANK_N high for 640 cycles per active line. X wraps 799->0 and Y increments.
- Frame timing: run 420000 cycles -> vs low during lines 490..491. oFrame_tick pulses once, at X=0,Y=480. Y wraps 524->0 together with X 799->0.
- Blank gating: iRed=iGreen=iBlue=1 constant -> RGB outputs 0 whenever oVGA_BLANK_N=0; 1 otherwise (border macro off).
- Mid-frame reset: assert reset_n=0 at X=300,Y=200 for 1 cycle -> next cycle X=0,Y=0; delay line outputs inactive for 2 cycles.
- VGA_TEST_BORDER_EN defined, inputs 0 -> white only at X∈{0,639} or Y∈{0,479}, black elsewhere.
